// File: rtl/demux_lane_sched_pkg.sv
// Shared definitions for the two-lane demux scheduler: state encoding,
// lane count and default data width.
package demux_lane_sched_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int NUM_LANES      = 2;
  localparam int LANE_W         = $clog2(NUM_LANES);

  typedef logic [1:0]        state_t;
  typedef logic [LANE_W-1:0] lane_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACTIVE = 2'd1;
  localparam state_t ST_DRAIN  = 2'd2;

endpackage

// File: rtl/sched_skid_fifo.sv
// Two-entry skid FIFO feeding the lane scheduler. Push is ignored when full,
// and pop is ignored when empty. A simultaneous push and pop keeps occupancy.
module sched_skid_fifo
  import demux_lane_sched_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_idx;
  logic              rd_idx;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (occ != 2'd2);
  assign do_pop  = pop  && (occ != 2'd0);
  assign head    = mem[rd_idx];

  // NOTE: storage is deliberately left out of reset; occupancy alone decides
  // which entries are live, so clearing it is enough to discard contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) wr_idx <= ~wr_idx;
      if (do_pop)  rd_idx <= ~rd_idx;
      occ <= occ + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/demux_lane_sched.sv
// Two-lane demux scheduler: buffers upstream words in a 2-entry FIFO and
// dispatches them to lane 0 or 1, alternating or skipping paused lanes.
module demux_lane_sched
  import demux_lane_sched_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              enable,
  input  logic              mode,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_out,
  input  logic              pause0,
  input  logic              pause1,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic              sel,
  output logic [7:0]        count0,
  output logic [7:0]        count1
);

  state_t                state;
  state_t                state_next;
  lane_t                 ptr;
  lane_t                 alt;
  lane_t                 lane;
  logic                  lane_ok;
  logic                  running;
  logic                  push;
  logic                  pop;
  logic [1:0]            occ;
  logic [1:0]            occ_next;
  logic [DATA_W-1:0]     head;
  logic [NUM_LANES-1:0]  pause_vec;

  sched_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk     (clk),
    .reset_L (reset_L),
    .push    (push),
    .pop     (pop),
    .din     (data_in),
    .head    (head),
    .occ     (occ)
  );

  assign pause_vec = {pause1, pause0};
  assign alt       = ~ptr;
  assign running   = (state == ST_ACTIVE) || (state == ST_DRAIN);
  assign ready_out = (state == ST_ACTIVE) && (occ < 2'(FIFO_DEPTH));
  assign push      = valid_in && ready_out;
  assign pop       = running && (occ != 2'd0) && lane_ok;
  assign occ_next  = occ + 2'(push) - 2'(pop);

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    lane    = ptr;
    lane_ok = 1'b0;
    if (!pause_vec[ptr]) begin
      lane_ok = 1'b1;
    end else if (mode && !pause_vec[alt]) begin
      lane    = alt;
      lane_ok = 1'b1;
    end
  end

  // Leaving ACTIVE/DRAIN looks at post-edge occupancy so a word accepted or
  // popped on the same edge is accounted for.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (enable) state_next = ST_ACTIVE;
      ST_ACTIVE: if (!enable) state_next = (occ_next != 2'd0) ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: begin
        if (enable)                 state_next = ST_ACTIVE;
        else if (occ_next == 2'd0)  state_next = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      sel        <= 1'b0;
      valid_out0 <= 1'b0;
      valid_out1 <= 1'b0;
      data_out0  <= '0;
      data_out1  <= '0;
      count0     <= 8'd0;
      count1     <= 8'd0;
    end else begin
      state      <= state_next;
      valid_out0 <= pop && (lane == lane_t'(0));
      valid_out1 <= pop && (lane == lane_t'(1));
      if (state_next == ST_IDLE) ptr <= '0;
      else if (pop)              ptr <= ~lane;
      if (pop) begin
        sel <= lane[0];
        if (lane == lane_t'(0)) begin
          data_out0 <= head;
          count0    <= count0 + 8'd1;
        end else begin
          data_out1 <= head;
          count1    <= count1 + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_lane_sched.sv
// Directed self-checking bench for demux_lane_sched: sequence, stall, skip,
// drain, counter wrap and mid-stream reset.
module tb_demux_lane_sched;

  logic       clk;
  logic       reset_L;
  logic       enable;
  logic       mode;
  logic       valid_in;
  logic [7:0] data_in;
  logic       ready_out;
  logic       pause0;
  logic       pause1;
  logic       valid_out0;
  logic       valid_out1;
  logic [7:0] data_out0;
  logic [7:0] data_out1;
  logic       sel;
  logic [7:0] count0;
  logic [7:0] count1;

  int total = 0;
  int bad   = 0;

  demux_lane_sched #(.DATA_W(8), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .enable     (enable),
    .mode       (mode),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .ready_out  (ready_out),
    .pause0     (pause0),
    .pause1     (pause1),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .sel        (sel),
    .count0     (count0),
    .count1     (count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, " v0"}, 32'(valid_out0), 32'd0);
    check({tag, " v1"}, 32'(valid_out1), 32'd0);
  endtask

  task automatic chk_disp(input string tag, input logic l, input logic [7:0] d);
    check({tag, " v0"}, 32'(valid_out0), 32'(l == 1'b0));
    check({tag, " v1"}, 32'(valid_out1), 32'(l == 1'b1));
    check({tag, " data"}, 32'(l ? data_out1 : data_out0), 32'(d));
    check({tag, " sel"}, 32'(sel), 32'(l));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_L  = 1'b0;
    enable   = 1'b0;
    mode     = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    pause0   = 1'b0;
    pause1   = 1'b0;
    #1;
    check("rst ready", 32'(ready_out), 32'd0);
    chk_idle("rst");
    check("rst d0", 32'(data_out0), 32'd0);
    check("rst d1", 32'(data_out1), 32'd0);
    check("rst sel", 32'(sel), 32'd0);
    check("rst c0", 32'(count0), 32'd0);
    check("rst c1", 32'(count1), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;

    // Idle with enable low: nothing accepted
    tick();
    check("idle ready", 32'(ready_out), 32'd0);
    enable = 1'b1;
    tick();
    check("active ready", 32'(ready_out), 32'd1);

    // Sequence: strict alternation
    valid_in = 1'b1; data_in = 8'hFF; tick(); chk_idle("seq latency");
    data_in = 8'hDD; tick(); chk_disp("seq FF", 1'b0, 8'hFF);
    data_in = 8'hEE; tick(); chk_disp("seq DD", 1'b1, 8'hDD);
    data_in = 8'hCC; tick(); chk_disp("seq EE", 1'b0, 8'hEE);
    valid_in = 1'b0; tick(); chk_disp("seq CC", 1'b1, 8'hCC);
    tick();
    chk_idle("seq after");
    check("seq hold d0", 32'(data_out0), 32'hEE);
    check("seq hold d1", 32'(data_out1), 32'hCC);
    check("seq c0", 32'(count0), 32'd2);
    check("seq c1", 32'(count1), 32'd2);

    // Stall: strict mode with lane 1 paused
    pause1 = 1'b1;
    valid_in = 1'b1; data_in = 8'hBB; tick(); chk_idle("stall latency");
    data_in = 8'h99; tick(); chk_disp("stall BB", 1'b0, 8'hBB);
    data_in = 8'hAA; tick(); chk_idle("stall wait");
    check("stall full ready", 32'(ready_out), 32'd0);
    valid_in = 1'b0; tick(); chk_idle("stall hold");
    check("stall hold ready", 32'(ready_out), 32'd0);
    pause1 = 1'b0;
    tick(); chk_disp("stall 99", 1'b1, 8'h99);
    tick(); chk_disp("stall AA", 1'b0, 8'hAA);
    check("stall c0", 32'(count0), 32'd4);
    check("stall c1", 32'(count1), 32'd3);

    // Skip: work-conserving mode, lane 1 paused, pointer must stay at 1
    mode = 1'b1; pause1 = 1'b1;
    valid_in = 1'b1; data_in = 8'h88; tick(); chk_idle("skip latency");
    data_in = 8'h77; tick(); chk_disp("skip 88", 1'b0, 8'h88);
    valid_in = 1'b0; tick(); chk_disp("skip 77", 1'b0, 8'h77);
    check("skip c0", 32'(count0), 32'd6);
    check("skip c1", 32'(count1), 32'd3);
    pause1 = 1'b0;
    valid_in = 1'b1; data_in = 8'h66; tick(); chk_idle("skip ptr latency");
    valid_in = 1'b0; tick(); chk_disp("skip ptr 66", 1'b1, 8'h66);

    // Drain: two words buffered behind paused lanes, then disable
    mode = 1'b0; pause0 = 1'b1; pause1 = 1'b1;
    valid_in = 1'b1; data_in = 8'h11; tick(); chk_idle("drain fill1");
    data_in = 8'h22; tick(); chk_idle("drain fill2");
    valid_in = 1'b0;
    check("drain full ready", 32'(ready_out), 32'd0);
    enable = 1'b0; tick(); chk_idle("drain enter");
    check("drain ready", 32'(ready_out), 32'd0);
    pause0 = 1'b0; pause1 = 1'b0;
    tick(); chk_disp("drain 11", 1'b0, 8'h11);
    check("drain ready occ1", 32'(ready_out), 32'd0);
    tick(); chk_disp("drain 22", 1'b1, 8'h22);
    tick(); chk_idle("drain idle");
    check("drain idle ready", 32'(ready_out), 32'd0);
    check("drain c0", 32'(count0), 32'd7);
    check("drain c1", 32'(count1), 32'd5);

    // Wrap: back-to-back dispatches to lane 0 until count0 rolls over
    mode = 1'b1; pause1 = 1'b1; enable = 1'b1;
    tick();
    check("wrap ready", 32'(ready_out), 32'd1);
    valid_in = 1'b1;
    for (int i = 0; i < 248; i++) begin
      data_in = 8'(i);
      tick();
    end
    valid_in = 1'b0;
    tick();
    check("wrap c0 ff", 32'(count0), 32'hFF);
    check("wrap last data", 32'(data_out0), 32'hF7);
    check("wrap c1", 32'(count1), 32'd5);
    valid_in = 1'b1; data_in = 8'h5A; tick();
    valid_in = 1'b0; tick(); chk_disp("wrap 5A", 1'b0, 8'h5A);
    check("wrap c0 00", 32'(count0), 32'h00);

    // Reset mid-stream with two words buffered
    mode = 1'b0; pause0 = 1'b1; pause1 = 1'b1;
    valid_in = 1'b1; data_in = 8'h33; tick();
    data_in = 8'h44; tick();
    valid_in = 1'b0;
    chk_idle("rst2 buffered");
    #2 reset_L = 1'b0;
    #1;
    check("rst2 d0", 32'(data_out0), 32'd0);
    check("rst2 d1", 32'(data_out1), 32'd0);
    check("rst2 c1", 32'(count1), 32'd0);
    check("rst2 ready", 32'(ready_out), 32'd0);
    #1 reset_L = 1'b1;
    pause0 = 1'b0; pause1 = 1'b0; enable = 1'b1;
    valid_in = 1'b1; data_in = 8'hD0;
    tick(); chk_idle("rst2 enable");
    check("rst2 ready on", 32'(ready_out), 32'd1);
    data_in = 8'hE1; tick(); chk_idle("rst2 accept");
    valid_in = 1'b0; tick(); chk_disp("rst2 E1", 1'b0, 8'hE1);
    tick(); chk_idle("rst2 end");
    check("rst2 c0", 32'(count0), 32'd1);
    check("rst2 c1 end", 32'(count1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_lane_sched.md
DEMUX_LANE_SCHED -- requirements
Module: demux_lane_sched

Interface
REQ-001 Parameter: DATA_W, default 8, width of the data word.
REQ-002 Parameter: FIFO_DEPTH, default 2, number of skid-buffer entries (fixed at 2 for this revision).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  scheduler run request from the configuration logic.
REQ-006 mode  input  1  0 = strict alternation between lanes; 1 = work-conserving (skip a paused lane).
REQ-007 valid_in  input  1  upstream word valid.
REQ-008 data_in  input  DATA_W  upstream word.
REQ-009 ready_out  output  1  scheduler can accept a word this cycle.
REQ-010 pause0, pause1  input  1 each  downstream lane N is almost full; do not dispatch to it.
REQ-011 valid_out0, valid_out1  output  1 each  registered word-valid for lane N.
REQ-012 data_out0, data_out1  output  DATA_W each  registered word for lane N.
REQ-013 sel  output  1  lane of the most recent dispatch (demux select).
REQ-014 count0, count1  output  8 each  words dispatched per lane.

Function
REQ-015 A word SHALL be accepted at a rising edge where valid_in=1 and ready_out=1, and pushed into a 2-entry FIFO.
REQ-016 ready_out SHALL be combinational from registered state: 1 only when state=ACTIVE and FIFO occupancy < 2.
REQ-017 FSM states SHALL be IDLE, ACTIVE, DRAIN.
REQ-018 IDLE->ACTIVE SHALL occur when enable=1.
REQ-019 ACTIVE->DRAIN SHALL occur when enable=0 and the FIFO is non-empty.
REQ-020 ACTIVE->IDLE SHALL occur when enable=0 and the FIFO is empty.
REQ-021 DRAIN->IDLE SHALL occur when the FIFO becomes empty; DRAIN->ACTIVE SHALL occur when enable=1.
REQ-022 In DRAIN, ready_out=0 and dispatch SHALL continue; in IDLE, there SHALL be no accept and no dispatch.
REQ-023 A target-lane pointer ptr SHALL select the preferred lane; it is 0 after reset and set to 0 on entry to IDLE.
REQ-024 Dispatch SHALL occur at an edge where the FIFO is non-empty, state is ACTIVE or DRAIN, and the chosen lane is unpaused.
REQ-025 On dispatch the FIFO head SHALL pop into data_outN with valid_outN=1; all other valid_out signals are 0 that cycle.
REQ-026 mode=0 lane choice: the lane is always ptr; if pause[ptr]=1, the scheduler SHALL stall.
REQ-027 mode=1 lane choice: the lane is ptr if unpaused, else the other lane if unpaused, else stall.
REQ-028 After dispatching to lane L, ptr SHALL become ~L and sel SHALL become L.
REQ-029 Latency SHALL be one cycle: a word accepted into an empty FIFO at edge k appears on the outputs after edge k+1, provided its lane is unpaused.
REQ-030 Push and pop in the same edge SHALL be legal; occupancy is then unchanged.
REQ-031 No push SHALL occur at occupancy 2, even when a pop happens that edge.
REQ-032 Words SHALL leave in acceptance order; no word is dropped or duplicated.
REQ-033 pause sampled at edge k SHALL govern the dispatch decision at edge k.
REQ-034 Non-dispatch cycles SHALL drive valid_outN=0 while data_outN holds its last value.
REQ-035 countN SHALL increment by 1 per dispatch to lane N and wrap 0xFF->0x00.
REQ-036 Counters SHALL be cleared only by reset.

Reset
REQ-037 With reset_L=0, the block SHALL asynchronously set state=IDLE, FIFO empty, ptr=0, sel=0, valid_out0/1=0, data_out0/1=0, count0/1=0; ready_out is therefore 0.
REQ-038 Reset mid-operation SHALL discard FIFO contents; the first accept after release occurs no earlier than the edge after enable is seen in IDLE.

Structure
REQ-039 The shared package/include SHALL hold the state encoding (IDLE=2'd0, ACTIVE=2'd1, DRAIN=2'd2), NUM_LANES=2, and the default DATA_W.
REQ-040 The design SHALL use one sub-module, sched_skid_fifo (2-entry FIFO: push, pop, head, occupancy); the FSM, lane choice and counters stay in demux_lane_sched.

Verification
REQ-041 Sequence test: mode=0, enable=1, pauses 0, stream FF,DD,EE,CC -> lane0 gets FF,EE; lane1 gets DD,CC; count0=count1=2; sel alternates 0,1,0,1.
REQ-042 Stall test: mode=0, pause1=1, stream BB,99,AA -> lane0 gets BB; then stall; FIFO fills; ready_out=0. Release pause1 -> lane1 gets 99, lane0 gets AA.
REQ-043 Skip test: mode=1, pause1=1, stream 88,77 -> lane0 gets both; ptr stays 1; count0=2, count1=0.
REQ-044 Drain test: two words buffered with both lanes paused, then enable=0 -> state DRAIN, ready_out=0; unpause -> both words delivered, then IDLE.
REQ-045 Wrap test: 256 dispatches to lane0 (mode=1, pause1=1) -> count0 returns to 0x00.
REQ-046 Reset test: assert reset_L mid-stream with 2 words buffered -> outputs zero immediately; after re-enable, only new words appear.
